pdu_lq_sequencer: RTL and testbench

Upstream stage of the PDU patch decoder. Holds the logical-qubit-to-patch map and accepts a per-instruction mask of participating logical qubits. Walks the set bits in the mask, one logical qubit per handshake, and drives `lqidx`, `rd_pchidx0` and `rd_pchidx1` into the decoder. Signals completion so the downstream collector can close the instruction's patch lists.

---
 rtl/pdu_lq_sequencer_pkg.sv | 19 +
 rtl/pdu_lq_sequencer_prienc.sv | 23 ++
 rtl/pdu_lq_sequencer.sv | 158 +++++++++++++++
 tb/tb_pdu_lq_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pdu_lq_sequencer_pkg.sv
// Shared defaults and FSM state encoding for the PDU logical-qubit sequencer.
// Macro PDU_SEQ_SKIP_EN selects mask-bit skipping in pdu_lq_sequencer.
package pdu_lq_sequencer_pkg;

    localparam int DEF_NUM_LQ     = 8;
    localparam int DEF_NUM_PCH    = 16;
    localparam int DEF_LQADDR_BW  = 3;
    localparam int DEF_PCHADDR_BW = 5;

    localparam logic [DEF_PCHADDR_BW-1:0] DEF_PCHIDX_NONE = '1;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_LOAD  = 2'd1,
        SEQ_ISSUE = 2'd2,
        SEQ_DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/pdu_lq_sequencer_prienc.sv
// Lowest-set-bit priority encoder with an any-bit-set flag; purely combinational.
module pdu_lq_prienc #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    // Scanning downward lets the lowest set bit win the last assignment.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = W'(i);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pdu_lq_sequencer.sv
// Walks a logical-qubit mask one step per handshake, emitting each qubit's patch pair.
// PDU_SEQ_SKIP_EN: visit only set mask bits; otherwise visit every lq, masked-off ones as PCHIDX_NONE.
module pdu_lq_sequencer
    import pdu_lq_sequencer_pkg::*;
#(
    parameter int NUM_LQ     = DEF_NUM_LQ,
    parameter int NUM_PCH    = DEF_NUM_PCH,
    parameter int LQADDR_BW  = DEF_LQADDR_BW,
    parameter int PCHADDR_BW = DEF_PCHADDR_BW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  map_wr_en,
    input  logic [LQADDR_BW-1:0]  map_wr_lq,
    input  logic [PCHADDR_BW-1:0] map_wr_pch0,
    input  logic [PCHADDR_BW-1:0] map_wr_pch1,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [NUM_LQ-1:0]     lq_mask,
    output logic                  step_valid,
    input  logic                  step_ready,
    output logic [LQADDR_BW-1:0]  lqidx,
    output logic [PCHADDR_BW-1:0] rd_pchidx0,
    output logic [PCHADDR_BW-1:0] rd_pchidx1,
    output logic                  done,
    output logic                  busy
);

    localparam logic [PCHADDR_BW-1:0] PCHIDX_NONE = '1;

    // The all-ones index is reserved as "no patch", so real patches must stay below it.
    if (NUM_PCH >= (1 << PCHADDR_BW)) begin : g_bad_pch_cfg
        $error("NUM_PCH must be below 2**PCHADDR_BW");
    end

    seq_state_e            state_q;
    logic [NUM_LQ-1:0]     pending_q, pending_d;
    logic [PCHADDR_BW-1:0] map_pch0_q [NUM_LQ];
    logic [PCHADDR_BW-1:0] map_pch1_q [NUM_LQ];
    logic                  step_valid_q, done_q, busy_q, start_ready_q;
    logic [LQADDR_BW-1:0]  lqidx_q, sel_lq_d;
    logic [PCHADDR_BW-1:0] pch0_q, pch1_q, sel_pch0_d, sel_pch1_d;
    logic                  has_next;

`ifdef PDU_SEQ_SKIP_EN
    logic sel_any;

    pdu_lq_prienc #(
        .N (NUM_LQ),
        .W (LQADDR_BW)
    ) u_prienc (
        .req_i (pending_q),
        .idx_o (sel_lq_d),
        .any_o (sel_any)
    );

    always_comb begin
        has_next   = sel_any;
        sel_pch0_d = map_pch0_q[sel_lq_d];
        sel_pch1_d = map_pch1_q[sel_lq_d];
    end
`else
    localparam int CNT_BW = $clog2(NUM_LQ + 1);
    logic [CNT_BW-1:0] cnt_q;

    always_comb begin
        has_next   = cnt_q < CNT_BW'(NUM_LQ);
        sel_lq_d   = LQADDR_BW'(cnt_q);
        sel_pch0_d = PCHIDX_NONE;
        sel_pch1_d = PCHIDX_NONE;
        if (pending_q[sel_lq_d]) begin
            sel_pch0_d = map_pch0_q[sel_lq_d];
            sel_pch1_d = map_pch1_q[sel_lq_d];
        end
    end
`endif

    assign pending_d = pending_q & ~(NUM_LQ'(1) << sel_lq_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LQ; i++) begin
                map_pch0_q[i] <= PCHIDX_NONE;
                map_pch1_q[i] <= PCHIDX_NONE;
            end
        end else if (map_wr_en && (32'(map_wr_lq) < 32'(NUM_LQ))) begin
            map_pch0_q[map_wr_lq] <= map_wr_pch0;
            map_pch1_q[map_wr_lq] <= map_wr_pch1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= SEQ_IDLE;
            pending_q     <= '0;
            step_valid_q  <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b1;
            lqidx_q       <= '0;
            pch0_q        <= PCHIDX_NONE;
            pch1_q        <= PCHIDX_NONE;
`ifndef PDU_SEQ_SKIP_EN
            cnt_q         <= '0;
`endif
        end else begin
            case (state_q)
                SEQ_IDLE: begin
                    if (start_valid) begin
                        pending_q     <= lq_mask;
                        start_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= SEQ_LOAD;
`ifndef PDU_SEQ_SKIP_EN
                        cnt_q         <= '0;
`endif
                    end
                end
                // LOAD and a completed ISSUE handshake share the same step-load path.
                SEQ_LOAD, SEQ_ISSUE: begin
                    if (state_q == SEQ_LOAD || step_ready) begin
                        if (has_next) begin
                            lqidx_q      <= sel_lq_d;
                            pch0_q       <= sel_pch0_d;
                            pch1_q       <= sel_pch1_d;
                            pending_q    <= pending_d;
                            step_valid_q <= 1'b1;
                            state_q      <= SEQ_ISSUE;
`ifndef PDU_SEQ_SKIP_EN
                            cnt_q        <= cnt_q + 1'b1;
`endif
                        end else begin
                            step_valid_q <= 1'b0;
                            done_q       <= 1'b1;
                            state_q      <= SEQ_DONE;
                        end
                    end
                end
                SEQ_DONE: begin
                    done_q        <= 1'b0;
                    busy_q        <= 1'b0;
                    start_ready_q <= 1'b1;
                    state_q       <= SEQ_IDLE;
                end
                default: state_q <= SEQ_IDLE;
            endcase
        end
    end

    assign start_ready = start_ready_q;
    assign step_valid  = step_valid_q;
    assign lqidx       = lqidx_q;
    assign rd_pchidx0  = pch0_q;
    assign rd_pchidx1  = pch1_q;
    assign done        = done_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_pdu_lq_sequencer.sv
// Directed bench for pdu_lq_sequencer; expectations adapt to PDU_SEQ_SKIP_EN.
module tb_pdu_lq_sequencer;

    localparam int NUM_LQ = 8;
    localparam int NUM_PCH = 16;
    localparam int LQADDR_BW = 3;
    localparam int PCHADDR_BW = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       map_wr_en;
    logic [2:0] map_wr_lq;
    logic [4:0] map_wr_pch0, map_wr_pch1;
    logic       start_valid, start_ready;
    logic [7:0] lq_mask;
    logic       step_valid, step_ready;
    logic [2:0] lqidx;
    logic [4:0] rd_pchidx0, rd_pchidx1;
    logic       done, busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]       mask;
        int               stall;
        int               n;
        logic [7:0][12:0] seq;
    } vec_t;

    vec_t vecs [5];

    pdu_lq_sequencer #(
        .NUM_LQ     (NUM_LQ),
        .NUM_PCH    (NUM_PCH),
        .LQADDR_BW  (LQADDR_BW),
        .PCHADDR_BW (PCHADDR_BW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .map_wr_en   (map_wr_en),
        .map_wr_lq   (map_wr_lq),
        .map_wr_pch0 (map_wr_pch0),
        .map_wr_pch1 (map_wr_pch1),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .lq_mask     (lq_mask),
        .step_valid  (step_valid),
        .step_ready  (step_ready),
        .lqidx       (lqidx),
        .rd_pchidx0  (rd_pchidx0),
        .rd_pchidx1  (rd_pchidx1),
        .done        (done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [12:0] st(input logic [2:0] lq, input logic [4:0] p0, input logic [4:0] p1);
        return {lq, p0, p1};
    endfunction

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_step_valid"}, 32'(step_valid), 32'd0);
        chk({nm, "_done"}, 32'(done), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_start_ready"}, 32'(start_ready), 32'd1);
        chk({nm, "_lqidx"}, 32'(lqidx), 32'd0);
        chk({nm, "_pch"}, 32'({rd_pchidx0, rd_pchidx1}), 32'h3ff);
    endtask

    task automatic map_write(input logic [2:0] lq, input logic [4:0] p0, input logic [4:0] p1);
        map_wr_en = 1'b1; map_wr_lq = lq; map_wr_pch0 = p0; map_wr_pch1 = p1;
        tick();
        map_wr_en = 1'b0;
    endtask

    task automatic run_vec(input int vi, input vec_t v);
        int n;
        logic [12:0] exp_s [8];
`ifdef PDU_SEQ_SKIP_EN
        n = v.n;
        for (int k = 0; k < 8; k++) exp_s[k] = v.seq[k];
`else
        // Every lq is visited; only listed (selected) entries carry a map value.
        n = 8;
        for (int i = 0; i < 8; i++) exp_s[i] = st(3'(i), 5'd31, 5'd31);
        for (int k = 0; k < v.n; k++) exp_s[v.seq[k][12:10]] = v.seq[k];
`endif
        chk($sformatf("v%0d_idle_ready", vi), 32'(start_ready), 32'd1);
        start_valid = 1'b1; lq_mask = v.mask; step_ready = 1'b1;
        tick();
        start_valid = 1'b0;
        chk($sformatf("v%0d_t1_busy", vi), 32'(busy), 32'd1);
        chk($sformatf("v%0d_t1_nostep", vi), 32'({step_valid, done, start_ready}), 32'd0);
        tick();
        for (int k = 0; k < n; k++) begin
            if (k == 0) begin
                for (int s = 0; s < v.stall; s++) begin
                    step_ready = 1'b0;
                    chk($sformatf("v%0d_stall%0d", vi, s),
                        32'({step_valid, lqidx, rd_pchidx0, rd_pchidx1}), 32'({1'b1, exp_s[0]}));
                    tick();
                end
            end
            step_ready = 1'b1;
            chk($sformatf("v%0d_step%0d", vi, k),
                32'({step_valid, lqidx, rd_pchidx0, rd_pchidx1}), 32'({1'b1, exp_s[k]}));
            tick();
        end
        chk($sformatf("v%0d_done", vi), 32'({done, step_valid}), 32'b10);
        tick();
        chk($sformatf("v%0d_after", vi), 32'({done, busy, start_ready}), 32'b001);
    endtask

    task automatic run_find(input string nm, input logic [7:0] mask, input bit wr_mid,
                            input logic [2:0] lq, input logic [4:0] ep0, input logic [4:0] ep1);
        bit found, fin, wrote;
        found = 1'b0; fin = 1'b0; wrote = 1'b0;
        start_valid = 1'b1; lq_mask = mask; step_ready = 1'b1;
        tick();
        start_valid = 1'b0;
        for (int c = 0; c < 30 && !fin; c++) begin
            if (wr_mid && step_valid && !wrote) begin
                map_wr_en = 1'b1; map_wr_lq = 3'd5; map_wr_pch0 = 5'd9; map_wr_pch1 = 5'd10;
                step_ready = 1'b0;
                tick();
                map_wr_en = 1'b0; step_ready = 1'b1; wrote = 1'b1;
            end
            if (step_valid && lqidx == lq) begin
                found = 1'b1;
                chk({nm, "_pch"}, 32'({rd_pchidx0, rd_pchidx1}), 32'({ep0, ep1}));
            end
            if (done) fin = 1'b1;
            tick();
        end
        chk({nm, "_found"}, 32'(found), 32'd1);
        chk({nm, "_fin"}, 32'({fin, start_ready}), 32'b11);
    endtask

    initial begin
        int acc;
        bit seen;
        rst = 1'b1; map_wr_en = 1'b0; map_wr_lq = '0; map_wr_pch0 = '0; map_wr_pch1 = '0;
        start_valid = 1'b0; lq_mask = '0; step_ready = 1'b0;

        for (int i = 0; i < 5; i++) begin
            vecs[i].seq = '0;
            vecs[i].stall = 0;
        end
        vecs[0].mask = 8'h24; vecs[0].n = 2;
        vecs[0].seq[0] = st(3'd2, 5'd3, 5'd4); vecs[0].seq[1] = st(3'd5, 5'd7, 5'd7);
        vecs[1].mask = 8'h24; vecs[1].n = 2; vecs[1].stall = 3;
        vecs[1].seq[0] = st(3'd2, 5'd3, 5'd4); vecs[1].seq[1] = st(3'd5, 5'd7, 5'd7);
        vecs[2].mask = 8'h00; vecs[2].n = 0;
        vecs[3].mask = 8'h80; vecs[3].n = 1;
        vecs[3].seq[0] = st(3'd7, 5'd31, 5'd31);
        vecs[4].mask = 8'ha5; vecs[4].n = 4;
        vecs[4].seq[0] = st(3'd0, 5'd31, 5'd31); vecs[4].seq[1] = st(3'd2, 5'd3, 5'd4);
        vecs[4].seq[2] = st(3'd5, 5'd7, 5'd7);   vecs[4].seq[3] = st(3'd7, 5'd31, 5'd31);

        repeat (3) tick();
        chk_reset_outputs("in_reset");
        rst = 1'b0;
        tick();
        chk_reset_outputs("post_reset");

        map_write(3'd2, 5'd3, 5'd4);
        map_write(3'd5, 5'd7, 5'd7);

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // start_valid held through a whole run must yield a single accept.
        start_valid = 1'b1; lq_mask = 8'h24; step_ready = 1'b1;
        acc = 0; seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            if (start_ready) acc++;
            tick();
            if (done) seen = 1'b1;
        end
        start_valid = 1'b0;
        chk("held_start_accepts", 32'(acc), 32'd1);
        chk("held_start_done", 32'(seen), 32'd1);
        tick();
        chk("held_start_ready", 32'(start_ready), 32'd1);

        run_find("midrun_write", 8'h24, 1'b1, 3'd5, 5'd9, 5'd10);

        // Reset in the middle of a run: no done pulse, map cleared.
        start_valid = 1'b1; lq_mask = 8'h24; step_ready = 1'b1;
        tick();
        start_valid = 1'b0;
        tick();
        chk("rst_run_step", 32'(step_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outputs("mid_reset");
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (done || step_valid || busy) seen = 1'b1;
            tick();
        end
        chk("rst_no_activity", 32'(seen), 32'd0);
        run_find("rst_map_cleared", 8'h04, 1'b0, 3'd2, 5'd31, 5'd31);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
